// File: rtl/fpga_conf_regs.sv
`default_nettype none
// ============================================================================
//  Module      : fpga_conf_regs
//  Description : SPI-fed configuration register bank for the 13.56 MHz domain.
//                Decodes 16-bit write / read / soft-reset frames from the ARM
//                and drives the output-mux major mode through a blanking
//                sequence so the carrier never sees a half-switched mode.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module fpga_conf_regs #(
    parameter int         NUM_REGS     = 4,
    parameter int         DATA_W       = 8,
    parameter int         GUARD_CYCLES = 16,
    parameter logic [7:0] REG0_RESET   = 8'hE0
) (
    input  logic                         ck_1356meg,
    input  logic                         nrst,
    input  logic                         spck,
    input  logic                         mosi,
    input  logic                         ncs,
    output logic                         miso,
    output logic [NUM_REGS*DATA_W-1:0]   conf_regs,
    output logic [2:0]                   major_mode_out,
    output logic                         mode_switching,
    output logic                         wr_strobe,
    output logic [3:0]                   wr_addr,
    output logic [3:0]                   frame_err_cnt
);

    localparam int         c_CNT_W     = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(GUARD_CYCLES - 1);
    localparam logic [4:0] c_FRAME_BITS = 5'd16;
    localparam logic [4:0] c_BITCNT_SAT = 5'd17;
    localparam logic [3:0] c_CMD_WRITE  = 4'b0001;
    localparam logic [3:0] c_CMD_READ   = 4'b0010;
    localparam logic [3:0] c_CMD_SRST   = 4'b0011;
    localparam logic [2:0] c_MODE_OFF   = 3'b111;
    localparam logic [0:0] c_S_ACTIVE   = 1'b0;
    localparam logic [0:0] c_S_BLANK    = 1'b1;

    // ------------------------------------------------------------------------
    // Input synchronisation and edge detection
    // ------------------------------------------------------------------------
    logic [1:0] r_spck_sync, r_mosi_sync, r_ncs_sync;
    logic       r_spck_d, r_ncs_d;

    // Identical 2-flop chains keep spck/mosi/ncs mutually aligned; ncs idles high
    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            r_spck_sync <= 2'b00;
            r_mosi_sync <= 2'b00;
            r_ncs_sync  <= 2'b11;
            r_spck_d    <= 1'b0;
            r_ncs_d     <= 1'b1;
        end else begin
            r_spck_sync <= {r_spck_sync[0], spck};
            r_mosi_sync <= {r_mosi_sync[0], mosi};
            r_ncs_sync  <= {r_ncs_sync[0], ncs};
            r_spck_d    <= r_spck_sync[1];
            r_ncs_d     <= r_ncs_sync[1];
        end
    end

    logic w_spck_s, w_mosi_s, w_ncs_s;
    logic w_spck_rise, w_spck_fall, w_ncs_rise, w_ncs_fall;
    assign w_spck_s    = r_spck_sync[1];
    assign w_mosi_s    = r_mosi_sync[1];
    assign w_ncs_s     = r_ncs_sync[1];
    assign w_spck_rise = w_spck_s & ~r_spck_d;
    assign w_spck_fall = ~w_spck_s & r_spck_d;
    assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;
    assign w_ncs_fall  = ~w_ncs_s & r_ncs_d;

    // ------------------------------------------------------------------------
    // Shift-in and frame decode
    // ------------------------------------------------------------------------
    logic [15:0] r_shift;
    logic [4:0]  r_bitcnt;

    // Collect MOSI bits; the bit counter saturates so over-long frames stay invalid
    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
        end else if (w_ncs_fall) begin
            r_bitcnt <= '0;
        end else if (w_spck_rise && !w_ncs_s) begin
            r_shift <= {r_shift[14:0], w_mosi_s};
            if (r_bitcnt != c_BITCNT_SAT) begin
                r_bitcnt <= r_bitcnt + 5'd1;
            end
        end
    end

    logic [3:0] w_cmd, w_addr;
    logic       w_frame_ok, w_addr_in_range, w_wr_ok, w_rd_cmd, w_srst;
    assign w_cmd           = r_shift[15:12];
    assign w_addr          = r_shift[11:8];
    assign w_frame_ok      = w_ncs_rise && (r_bitcnt == c_FRAME_BITS);
    assign w_addr_in_range = ({28'd0, w_addr} < NUM_REGS);
    assign w_wr_ok         = w_frame_ok && (w_cmd == c_CMD_WRITE) && w_addr_in_range;
    assign w_rd_cmd        = w_frame_ok && (w_cmd == c_CMD_READ);
    assign w_srst          = w_frame_ok && (w_cmd == c_CMD_SRST);

    // ------------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // Write and soft-reset; loop compare avoids an address slice that breaks for NUM_REGS=1
    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == 0) ? REG0_RESET[DATA_W-1:0] : '0;
            end
        end else if (w_srst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == 0) ? REG0_RESET[DATA_W-1:0] : '0;
            end
        end else if (w_wr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_addr == 4'(i)) begin
                    r_regs[i] <= r_shift[DATA_W-1:0];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_conf
        assign conf_regs[g*DATA_W +: DATA_W] = r_regs[g];
    end

    logic       r_wr_strobe;
    logic [3:0] r_wr_addr;
    logic [3:0] r_err_cnt;

    // Write strobe/address report and saturating discarded-frame counter
    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_wr_strobe <= w_wr_ok | w_srst;
            if (w_wr_ok) begin
                r_wr_addr <= w_addr;
            end else if (w_srst) begin
                r_wr_addr <= '0;
            end
            if (w_ncs_rise && (r_bitcnt != c_FRAME_BITS) && (r_err_cnt != 4'hF)) begin
                r_err_cnt <= r_err_cnt + 4'd1;
            end
        end
    end

    assign wr_strobe     = r_wr_strobe;
    assign wr_addr       = r_wr_addr;
    assign frame_err_cnt = r_err_cnt;

    // ------------------------------------------------------------------------
    // Readback
    // ------------------------------------------------------------------------
    logic [DATA_W-1:0] w_rd_data;
    logic              r_pending_rd;
    logic [3:0]        r_rd_addr;
    logic [15:0]       r_rd_buf;

    // Selected readback register; out-of-range addresses read as zero
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_rd_addr == 4'(i)) begin
                w_rd_data = r_regs[i];
            end
        end
    end

    // Load the read buffer at the start of the frame after a READ, then shift MSB first
    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            r_pending_rd <= 1'b0;
            r_rd_addr    <= '0;
            r_rd_buf     <= '0;
        end else begin
            if (w_ncs_fall) begin
                r_rd_buf     <= r_pending_rd ? {{(16-DATA_W){1'b0}}, w_rd_data} : 16'h0000;
                r_pending_rd <= 1'b0;
            end else if (w_spck_fall && !w_ncs_s) begin
                r_rd_buf <= {r_rd_buf[14:0], 1'b0};
            end
            if (w_rd_cmd) begin
                r_pending_rd <= 1'b1;
                r_rd_addr    <= w_addr;
            end
        end
    end

    assign miso = w_ncs_s ? 1'b0 : r_rd_buf[15];

    // ------------------------------------------------------------------------
    // Major-mode switching FSM
    // ------------------------------------------------------------------------
    logic [2:0]         w_tgt;
    logic [0:0]         r_state, w_state_nxt;
    logic [2:0]         r_cur, w_cur_nxt, r_tgt_seen, w_tgt_seen_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]         r_mode_out, w_mode_nxt;
    logic               r_mode_sw, w_sw_nxt;

    // Target mode lives in the top three bits of reg 0
    assign w_tgt = r_regs[0][DATA_W-1 -: 3];

    // State register; mode outputs are registered so the mux select cannot glitch
    always_ff @(posedge ck_1356meg or negedge nrst) begin
        if (!nrst) begin
            r_state    <= c_S_ACTIVE;
            r_cur      <= c_MODE_OFF;
            r_tgt_seen <= c_MODE_OFF;
            r_cnt      <= '0;
            r_mode_out <= c_MODE_OFF;
            r_mode_sw  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cur      <= w_cur_nxt;
            r_tgt_seen <= w_tgt_seen_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mode_out <= w_mode_nxt;
            r_mode_sw  <= w_sw_nxt;
        end
    end

    // Next state: any target change (re)starts a full guard interval of blanking
    always_comb begin
        w_state_nxt    = r_state;
        w_cur_nxt      = r_cur;
        w_tgt_seen_nxt = r_tgt_seen;
        w_cnt_nxt      = r_cnt;
        case (r_state)
            c_S_ACTIVE: begin
                if (w_tgt != r_cur) begin
                    w_state_nxt    = c_S_BLANK;
                    w_cnt_nxt      = c_CNT_LOAD;
                    w_tgt_seen_nxt = w_tgt;
                end
            end
            c_S_BLANK: begin
                if (w_tgt != r_tgt_seen) begin
                    w_cnt_nxt      = c_CNT_LOAD;
                    w_tgt_seen_nxt = w_tgt;
                end else if (r_cnt == '0) begin
                    w_cur_nxt   = w_tgt;
                    w_state_nxt = c_S_ACTIVE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = c_S_ACTIVE;
        endcase
        w_mode_nxt = (w_state_nxt == c_S_BLANK) ? c_MODE_OFF : w_cur_nxt;
        w_sw_nxt   = (w_state_nxt == c_S_BLANK);
    end

    assign major_mode_out = r_mode_out;
    assign mode_switching = r_mode_sw;

endmodule
`default_nettype wire
